// File: rtl/cdb_arbiter.sv
// Completion arbiter: one holding register per FU, round-robin grant of up to
// WAYS held entries per cycle (at most one branch), registered CDB lane outputs.
`ifndef SUPERSCALAR_WAYS
`define SUPERSCALAR_WAYS 3
`endif

module cdb_arbiter #(
  parameter int NUM_FU = 5,
  parameter int WAYS   = `SUPERSCALAR_WAYS,
  parameter int PR_W   = 6,
  parameter int ROB_W  = 5,
  parameter int XLEN   = 32
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             squash,
  input  logic [NUM_FU-1:0]                fu_valid,
  input  logic [NUM_FU*PR_W-1:0]           fu_pr_idx,
  input  logic [NUM_FU*ROB_W-1:0]          fu_rob_idx,
  input  logic [NUM_FU*XLEN-1:0]           fu_dest_value,
  input  logic [NUM_FU-1:0]                fu_take_branch,
  input  logic [NUM_FU*XLEN-1:0]           fu_target_pc,
  output logic [NUM_FU-1:0]                fu_stall,
  output logic [WAYS-1:0]                  out_valid,
  output logic [WAYS*PR_W-1:0]             out_pr_idx,
  output logic [WAYS*ROB_W-1:0]            out_rob_idx,
  output logic [WAYS*XLEN-1:0]             out_dest_value,
  output logic [WAYS-1:0]                  out_take_branch,
  output logic [WAYS*XLEN-1:0]             out_target_pc,
  output logic [WAYS*$clog2(NUM_FU)-1:0]   out_fu_id
);

  localparam int FU_W  = $clog2(NUM_FU);
  localparam int CNT_W = $clog2(WAYS + 1);

  logic [NUM_FU-1:0] hold_valid;
  logic [PR_W-1:0]   hold_pr_p0  [NUM_FU];
  logic [ROB_W-1:0]  hold_rob_p0 [NUM_FU];
  logic [XLEN-1:0]   hold_val_p0 [NUM_FU];
  logic [XLEN-1:0]   hold_pc_p0  [NUM_FU];
  logic [NUM_FU-1:0] hold_br_p0;
  logic [FU_W-1:0]   rr_ptr;

  logic [NUM_FU-1:0] grant;
  logic [NUM_FU-1:0] capture;
  logic [WAYS-1:0]   lane_vld;
  logic [FU_W-1:0]   lane_sel [WAYS];
  logic [CNT_W-1:0]  gcnt;
  logic              br_used;
  logic [FU_W-1:0]   last_fu;
  logic [FU_W:0]     scan;
  logic [FU_W-1:0]   idx;
  logic [FU_W-1:0]   rr_next;

  // Grant scan over registered holds only; a second branch is skipped without using a lane
  always_comb begin
    grant    = '0;
    lane_vld = '0;
    gcnt     = '0;
    br_used  = 1'b0;
    last_fu  = rr_ptr;
    scan     = '0;
    idx      = '0;
    for (int j = 0; j < WAYS; j++) lane_sel[j] = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan = {1'b0, rr_ptr} + (FU_W+1)'(k);
      if (scan >= (FU_W+1)'(NUM_FU)) scan = scan - (FU_W+1)'(NUM_FU);
      idx = scan[FU_W-1:0];
      if (hold_valid[idx] && (gcnt < CNT_W'(WAYS)) && !(br_used && hold_br_p0[idx])) begin
        grant[idx] = 1'b1;
        for (int j = 0; j < WAYS; j++) begin
          if (gcnt == CNT_W'(j)) begin
            lane_sel[j] = idx;
            lane_vld[j] = 1'b1;
          end
        end
        gcnt    = gcnt + 1'b1;
        br_used = br_used | hold_br_p0[idx];
        last_fu = idx;
      end
    end
  end

  assign fu_stall = hold_valid & ~grant & {NUM_FU{~squash}};
  assign capture  = fu_valid & ~fu_stall & {NUM_FU{~squash}};
  assign rr_next  = (last_fu == FU_W'(NUM_FU - 1)) ? '0 : last_fu + 1'b1;

  // Stage p0: FU holding registers and arbitration state
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid <= '0;
      rr_ptr     <= '0;
    end else if (squash) begin
      hold_valid <= '0;
    end else begin
      hold_valid <= capture | (hold_valid & ~grant);
      if (gcnt != '0) rr_ptr <= rr_next;
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_FU; i++) begin
      if (capture[i]) begin
        hold_pr_p0[i]  <= fu_pr_idx[i*PR_W +: PR_W];
        hold_rob_p0[i] <= fu_rob_idx[i*ROB_W +: ROB_W];
        hold_val_p0[i] <= fu_dest_value[i*XLEN +: XLEN];
        hold_pc_p0[i]  <= fu_target_pc[i*XLEN +: XLEN];
        hold_br_p0[i]  <= fu_take_branch[i];
      end
    end
  end

  // Stage p1: registered lane outputs; unused lanes carry zero payload
  always_ff @(posedge clock) begin
    if (reset || squash) begin
      out_valid       <= '0;
      out_pr_idx      <= '0;
      out_rob_idx     <= '0;
      out_dest_value  <= '0;
      out_take_branch <= '0;
      out_target_pc   <= '0;
      out_fu_id       <= '0;
    end else begin
      out_valid <= lane_vld;
      for (int j = 0; j < WAYS; j++) begin
        if (lane_vld[j]) begin
          out_pr_idx[j*PR_W +: PR_W]     <= hold_pr_p0[lane_sel[j]];
          out_rob_idx[j*ROB_W +: ROB_W]  <= hold_rob_p0[lane_sel[j]];
          out_dest_value[j*XLEN +: XLEN] <= hold_val_p0[lane_sel[j]];
          out_take_branch[j]             <= hold_br_p0[lane_sel[j]];
          out_target_pc[j*XLEN +: XLEN]  <= hold_pc_p0[lane_sel[j]];
          out_fu_id[j*FU_W +: FU_W]      <= lane_sel[j];
        end else begin
          out_pr_idx[j*PR_W +: PR_W]     <= '0;
          out_rob_idx[j*ROB_W +: ROB_W]  <= '0;
          out_dest_value[j*XLEN +: XLEN] <= '0;
          out_take_branch[j]             <= 1'b0;
          out_target_pc[j*XLEN +: XLEN]  <= '0;
          out_fu_id[j*FU_W +: FU_W]      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: per-scenario tasks with inline checks plus a
// scoreboard that matches every lane output against accepted FU packets.
module tb_cdb_arbiter;

  localparam int NUM_FU = 5;
  localparam int WAYS   = 3;
  localparam int PR_W   = 6;
  localparam int ROB_W  = 5;
  localparam int XLEN   = 32;
  localparam int FW     = 3;

  logic                      clock = 1'b0;
  logic                      reset;
  logic                      squash;
  logic [NUM_FU-1:0]         fu_valid;
  logic [NUM_FU*PR_W-1:0]    fu_pr_idx;
  logic [NUM_FU*ROB_W-1:0]   fu_rob_idx;
  logic [NUM_FU*XLEN-1:0]    fu_dest_value;
  logic [NUM_FU-1:0]         fu_take_branch;
  logic [NUM_FU*XLEN-1:0]    fu_target_pc;
  logic [NUM_FU-1:0]         fu_stall;
  logic [WAYS-1:0]           out_valid;
  logic [WAYS*PR_W-1:0]      out_pr_idx;
  logic [WAYS*ROB_W-1:0]     out_rob_idx;
  logic [WAYS*XLEN-1:0]      out_dest_value;
  logic [WAYS-1:0]           out_take_branch;
  logic [WAYS*XLEN-1:0]      out_target_pc;
  logic [WAYS*FW-1:0]        out_fu_id;

  cdb_arbiter #(.NUM_FU(NUM_FU), .WAYS(WAYS), .PR_W(PR_W), .ROB_W(ROB_W), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset), .squash(squash),
    .fu_valid(fu_valid), .fu_pr_idx(fu_pr_idx), .fu_rob_idx(fu_rob_idx),
    .fu_dest_value(fu_dest_value), .fu_take_branch(fu_take_branch),
    .fu_target_pc(fu_target_pc), .fu_stall(fu_stall),
    .out_valid(out_valid), .out_pr_idx(out_pr_idx), .out_rob_idx(out_rob_idx),
    .out_dest_value(out_dest_value), .out_take_branch(out_take_branch),
    .out_target_pc(out_target_pc), .out_fu_id(out_fu_id)
  );

  always #5 clock = ~clock;

  typedef struct {
    int              fu;
    logic [PR_W-1:0] pr;
    logic [ROB_W-1:0] rob;
    logic [XLEN-1:0] val;
    logic            br;
    logic [XLEN-1:0] pc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  function automatic logic [PR_W-1:0] pr_of(input int f, input int s);
    return PR_W'(f * 11 + s * 3 + 1);
  endfunction
  function automatic logic [ROB_W-1:0] rob_of(input int f, input int s);
    return ROB_W'(f * 7 + s * 5 + 2);
  endfunction
  function automatic logic [XLEN-1:0] val_of(input int f, input int s);
    return 32'hC000_0000 + XLEN'(f * 256 + s);
  endfunction
  function automatic logic [XLEN-1:0] pc_of(input int f, input int s);
    return 32'h0000_4000 + XLEN'(f * 64 + s * 4);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    fu_valid       = '0;
    fu_take_branch = '0;
  endtask

  task automatic drive_raw(input int f, input logic [PR_W-1:0] pr, input logic [ROB_W-1:0] rob,
                           input logic [XLEN-1:0] val, input logic br, input logic [XLEN-1:0] pc);
    fu_valid[f]                   = 1'b1;
    fu_pr_idx[f*PR_W +: PR_W]     = pr;
    fu_rob_idx[f*ROB_W +: ROB_W]  = rob;
    fu_dest_value[f*XLEN +: XLEN] = val;
    fu_take_branch[f]             = br;
    fu_target_pc[f*XLEN +: XLEN]  = pc;
  endtask

  task automatic drive_seq(input int f, input int s, input logic br);
    drive_raw(f, pr_of(f, s), rob_of(f, s), val_of(f, s), br, pc_of(f, s));
  endtask

  // Scoreboard: outputs matched oldest-first per source FU; accepted inputs pushed
  always @(negedge clock) begin
    if (reset) begin
      sb.delete();
    end else begin
      for (int j = 0; j < WAYS; j++) begin
        if (out_valid[j]) begin : lane_chk
          int   fid;
          int   hit;
          exp_t e;
          fid = int'(out_fu_id[j*FW +: FW]);
          hit = -1;
          for (int k = 0; k < sb.size(); k++) if (hit < 0 && sb[k].fu == fid) hit = k;
          checks++;
          if (hit < 0) begin
            $display("FAIL sb_lane%0d: got unexpected output fu=%0d pr=%h, required no output", j, fid,
                     out_pr_idx[j*PR_W +: PR_W]);
          end else begin
            e = sb[hit];
            sb.delete(hit);
            if (out_pr_idx[j*PR_W +: PR_W] !== e.pr || out_rob_idx[j*ROB_W +: ROB_W] !== e.rob ||
                out_dest_value[j*XLEN +: XLEN] !== e.val || out_take_branch[j] !== e.br ||
                out_target_pc[j*XLEN +: XLEN] !== e.pc)
              $display("FAIL sb_lane%0d fu%0d: got pr=%h rob=%h val=%h br=%b pc=%h required pr=%h rob=%h val=%h br=%b pc=%h",
                       j, fid, out_pr_idx[j*PR_W +: PR_W], out_rob_idx[j*ROB_W +: ROB_W],
                       out_dest_value[j*XLEN +: XLEN], out_take_branch[j], out_target_pc[j*XLEN +: XLEN],
                       e.pr, e.rob, e.val, e.br, e.pc);
            else passes++;
          end
        end
      end
      if (squash) begin
        sb.delete();
      end else begin
        for (int i = 0; i < NUM_FU; i++) begin
          if (fu_valid[i] && !fu_stall[i]) begin : push_blk
            exp_t n;
            n.fu  = i;
            n.pr  = fu_pr_idx[i*PR_W +: PR_W];
            n.rob = fu_rob_idx[i*ROB_W +: ROB_W];
            n.val = fu_dest_value[i*XLEN +: XLEN];
            n.br  = fu_take_branch[i];
            n.pc  = fu_target_pc[i*XLEN +: XLEN];
            sb.push_back(n);
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b1; squash = 1'b0;
    fu_pr_idx = '0; fu_rob_idx = '0; fu_dest_value = '0; fu_target_pc = '0; idle();
    for (int i = 0; i < NUM_FU; i++) drive_seq(i, 0, 1'b0);
    tick();
    @(negedge clock);
    checks++; if (out_valid !== 3'b000) $display("FAIL rst_out_valid: got %b required 000", out_valid); else passes++;
    checks++;
    if ({out_pr_idx, out_rob_idx, out_dest_value, out_take_branch, out_target_pc, out_fu_id} !== '0)
      $display("FAIL rst_payload: got pr=%h val=%h fu=%h required all zero", out_pr_idx, out_dest_value, out_fu_id);
    else passes++;
    checks++; if (fu_stall !== 5'b00000) $display("FAIL rst_stall: got %b required 00000", fu_stall); else passes++;
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++; if (fu_stall !== 5'b00000) $display("FAIL rst_rel_stall: got %b required 00000", fu_stall); else passes++;
    checks++; if (out_valid !== 3'b000) $display("FAIL rst_rel_valid: got %b required 000", out_valid); else passes++;
    tick();
    idle();
    @(negedge clock);
    checks++; if (fu_stall !== 5'b11000) $display("FAIL rst_first_stall: got %b required 11000", fu_stall); else passes++;
    tick();
    @(negedge clock);
    checks++; if (out_valid !== 3'b111) $display("FAIL rst_grant1_valid: got %b required 111", out_valid); else passes++;
    checks++; if (out_fu_id !== {3'd2, 3'd1, 3'd0}) $display("FAIL rst_grant1_fu: got %h required %h", out_fu_id, {3'd2, 3'd1, 3'd0}); else passes++;
    tick();
    @(negedge clock);
    checks++; if (out_valid !== 3'b011) $display("FAIL rst_grant2_valid: got %b required 011", out_valid); else passes++;
    checks++; if (out_fu_id !== {3'd0, 3'd4, 3'd3}) $display("FAIL rst_grant2_fu: got %h required %h", out_fu_id, {3'd0, 3'd4, 3'd3}); else passes++;
    tick();
    @(negedge clock);
    checks++; if (sb.size() != 0) $display("FAIL rst_drain: got %0d pending required 0", sb.size()); else passes++;
    tick();
  endtask

  task automatic test_single();
    drive_raw(2, 6'd7, 5'd3, 32'h0000_DEAD, 1'b0, 32'h0);
    @(negedge clock);
    checks++; if (fu_stall !== 5'b00000) $display("FAIL single_stall0: got %b required 00000", fu_stall); else passes++;
    tick();
    idle();
    @(negedge clock);
    checks++; if (out_valid !== 3'b000) $display("FAIL single_early: got %b required 000", out_valid); else passes++;
    tick();
    @(negedge clock);
    checks++; if (out_valid !== 3'b001) $display("FAIL single_valid: got %b required 001", out_valid); else passes++;
    checks++; if (out_fu_id[2:0] !== 3'd2) $display("FAIL single_fu: got %0d required 2", out_fu_id[2:0]); else passes++;
    checks++;
    if ({out_pr_idx[3*PR_W-1:PR_W], out_rob_idx[3*ROB_W-1:ROB_W], out_dest_value[3*XLEN-1:XLEN],
         out_target_pc[3*XLEN-1:XLEN], out_fu_id[3*FW-1:FW], out_take_branch[2:1]} !== '0)
      $display("FAIL single_idle_lanes: got pr=%h val=%h required zero", out_pr_idx, out_dest_value);
    else passes++;
    tick();
    @(negedge clock);
    checks++; if (out_valid !== 3'b000) $display("FAIL single_after: got %b required 000", out_valid); else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int cyc = 0; cyc < 8; cyc++) begin
      if (cyc < 5) drive_seq(4, 10 + cyc, 1'b0); else idle();
      @(negedge clock);
      if (cyc < 5) begin
        checks++; if (fu_stall !== 5'b00000) $display("FAIL b2b_stall c%0d: got %b required 00000", cyc, fu_stall); else passes++;
      end
      checks++;
      if (out_valid !== ((cyc >= 2 && cyc <= 6) ? 3'b001 : 3'b000))
        $display("FAIL b2b_valid c%0d: got %b required %b", cyc, out_valid, (cyc >= 2 && cyc <= 6) ? 3'b001 : 3'b000);
      else passes++;
      tick();
    end
    checks++; if (sb.size() != 0) $display("FAIL b2b_drain: got %0d pending required 0", sb.size()); else passes++;
  endtask

  task automatic test_oversub();
    int seq [NUM_FU];
    int run [NUM_FU];
    int max_run;
    max_run = 0;
    for (int i = 0; i < NUM_FU; i++) begin seq[i] = 40; run[i] = 0; end
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc < 8) for (int i = 0; i < NUM_FU; i++) drive_seq(i, seq[i], 1'b0);
      else idle();
      @(negedge clock);
      for (int i = 0; i < NUM_FU; i++) begin
        run[i] = fu_stall[i] ? run[i] + 1 : 0;
        if (run[i] > max_run) max_run = run[i];
        if (cyc < 8 && !fu_stall[i]) seq[i]++;
      end
      if (cyc == 1) begin
        checks++; if (fu_stall !== 5'b11000) $display("FAIL over_stall1: got %b required 11000", fu_stall); else passes++;
      end
      if (cyc == 2) begin
        checks++; if (fu_stall !== 5'b00110) $display("FAIL over_stall2: got %b required 00110", fu_stall); else passes++;
        checks++; if (out_fu_id !== {3'd2, 3'd1, 3'd0} || out_valid !== 3'b111)
          $display("FAIL over_lanes1: got fu=%h valid=%b required fu=%h valid=111", out_fu_id, out_valid, {3'd2, 3'd1, 3'd0});
        else passes++;
      end
      if (cyc == 3) begin
        checks++; if (fu_stall !== 5'b10001) $display("FAIL over_stall3: got %b required 10001", fu_stall); else passes++;
        checks++; if (out_fu_id !== {3'd0, 3'd4, 3'd3} || out_valid !== 3'b111)
          $display("FAIL over_lanes2: got fu=%h valid=%b required fu=%h valid=111", out_fu_id, out_valid, {3'd0, 3'd4, 3'd3});
        else passes++;
      end
      tick();
    end
    checks++; if (max_run !== 1) $display("FAIL over_wait: got max stall run %0d required 1", max_run); else passes++;
    checks++; if (sb.size() != 0) $display("FAIL over_drain: got %0d pending required 0", sb.size()); else passes++;
  endtask

  task automatic test_branch();
    reset = 1'b1; idle();
    tick();
    reset = 1'b0;
    drive_seq(1, 20, 1'b1); drive_seq(2, 20, 1'b0); drive_seq(3, 20, 1'b1);
    tick();
    idle();
    @(negedge clock);
    checks++; if (fu_stall !== 5'b01000) $display("FAIL br_stall: got %b required 01000", fu_stall); else passes++;
    tick();
    @(negedge clock);
    checks++; if (out_valid !== 3'b011 || out_fu_id !== {3'd0, 3'd2, 3'd1} || out_take_branch !== 3'b001)
      $display("FAIL br_lanes1: got valid=%b fu=%h br=%b required 011 %h 001", out_valid, out_fu_id, out_take_branch, {3'd0, 3'd2, 3'd1});
    else passes++;
    tick();
    @(negedge clock);
    checks++; if (out_valid !== 3'b001 || out_fu_id[2:0] !== 3'd3 || out_take_branch !== 3'b001)
      $display("FAIL br_lanes2: got valid=%b fu=%0d br=%b required 001 3 001", out_valid, out_fu_id[2:0], out_take_branch);
    else passes++;
    tick();
    drive_seq(4, 21, 1'b1); drive_seq(0, 21, 1'b1); drive_seq(1, 21, 1'b0); drive_seq(2, 21, 1'b0);
    tick();
    idle();
    @(negedge clock);
    checks++; if (fu_stall !== 5'b00001) $display("FAIL br_skip_stall: got %b required 00001", fu_stall); else passes++;
    tick();
    @(negedge clock);
    checks++; if (out_valid !== 3'b111 || out_fu_id !== {3'd2, 3'd1, 3'd4} || out_take_branch !== 3'b001)
      $display("FAIL br_skip_lanes: got valid=%b fu=%h br=%b required 111 %h 001", out_valid, out_fu_id, out_take_branch, {3'd2, 3'd1, 3'd4});
    else passes++;
    tick();
    @(negedge clock);
    checks++; if (out_valid !== 3'b001 || out_fu_id[2:0] !== 3'd0)
      $display("FAIL br_skip_late: got valid=%b fu=%0d required 001 0", out_valid, out_fu_id[2:0]);
    else passes++;
    tick();
    @(negedge clock);
    checks++; if (sb.size() != 0) $display("FAIL br_drain: got %0d pending required 0", sb.size()); else passes++;
    tick();
  endtask

  task automatic test_squash();
    for (int i = 1; i < NUM_FU; i++) drive_seq(i, 30, 1'b0);
    tick();
    idle();
    drive_seq(0, 30, 1'b0);
    squash = 1'b1;
    @(negedge clock);
    checks++; if (fu_stall !== 5'b00000) $display("FAIL sq_stall_mask: got %b required 00000", fu_stall); else passes++;
    tick();
    squash = 1'b0;
    for (int i = 0; i < NUM_FU; i++) drive_seq(i, 31, 1'b0);
    @(negedge clock);
    checks++; if (out_valid !== 3'b000) $display("FAIL sq_out_valid: got %b required 000", out_valid); else passes++;
    checks++; if (fu_stall !== 5'b00000) $display("FAIL sq_holds_empty: got %b required 00000", fu_stall); else passes++;
    tick();
    idle();
    @(negedge clock);
    checks++; if (out_valid !== 3'b000) $display("FAIL sq_no_leftover: got %b required 000", out_valid); else passes++;
    checks++; if (fu_stall !== 5'b10001) $display("FAIL sq_rr_kept: got %b required 10001", fu_stall); else passes++;
    tick();
    @(negedge clock);
    checks++; if (out_valid !== 3'b111 || out_fu_id !== {3'd3, 3'd2, 3'd1})
      $display("FAIL sq_regrant: got valid=%b fu=%h required 111 %h", out_valid, out_fu_id, {3'd3, 3'd2, 3'd1});
    else passes++;
    tick();
    tick();
    @(negedge clock);
    checks++; if (out_valid !== 3'b000) $display("FAIL sq_final_valid: got %b required 000", out_valid); else passes++;
    checks++; if (sb.size() != 0) $display("FAIL sq_drain: got %0d pending required 0", sb.size()); else passes++;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_oversub();
    test_branch();
    test_squash();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates completions from `NUM_FU` functional units onto `WAYS` CDB/complete lanes per cycle. It sits between the FU outputs and the complete stage. Each FU gets a one-entry holding register. Up to `WAYS` held results are granted per cycle in round-robin order, and the granted results are presented as registered lane outputs. FUs with an ungranted, occupied holding register are stalled.

## Interface
Parameters:
- `NUM_FU`, default 5: number of requesting functional units.
- `WAYS`, default `` `SUPERSCALAR_WAYS `` (3): output lanes per cycle.
- `PR_W`, default 6: physical register tag width.
- `ROB_W`, default 5: ROB index width.
- `XLEN`, default 32: data and PC width.

Ports:
- `clock` in 1: the single clock. All state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `squash` in 1: pipeline flush. Discards all held and output entries.
- `fu_valid` in `NUM_FU`: FU i presents a completion.
- `fu_pr_idx` in `NUM_FU`×`PR_W`: destination physical register.
- `fu_rob_idx` in `NUM_FU`×`ROB_W`: ROB index.
- `fu_dest_value` in `NUM_FU`×`XLEN`: result value.
- `fu_take_branch` in `NUM_FU`: resolved taken/mispredicted branch.
- `fu_target_pc` in `NUM_FU`×`XLEN`: branch target.
- `fu_stall` out `NUM_FU`: FU i must hold its output stable.
- `out_valid` out `WAYS`: lane j carries a completion.
- `out_pr_idx`, `out_rob_idx`, `out_dest_value`, `out_take_branch`, `out_target_pc` out, `WAYS`× field width: lane payload.
- `out_fu_id` out `WAYS`×`$clog2(NUM_FU)`: source FU of lane j.

## Operation
- **State.** Per FU: `hold_valid[i]` plus a payload register. One round-robin pointer `rr_ptr` (range 0..`NUM_FU`-1). Lane output registers.
- **Candidates.** Only entries with `hold_valid` set. Inputs are never granted in the same cycle they arrive.
- **Grant scan.** Scan FU indices `rr_ptr`, `rr_ptr`+1, … modulo `NUM_FU`. Grant each held entry until `WAYS` grants are made.
  - Grants fill lanes 0,1,2 in scan order.
  - At most one granted entry per cycle may have `take_branch`=1. Later branch entries in the scan are skipped; they are not granted and do not consume a lane.
- **Stall.** `fu_stall[i]` = `hold_valid[i]` & ~`grant[i]` & ~`squash`. This is combinational.
- **Capture.** Hold i loads `fu_*[i]` when `fu_valid[i]` & ~`fu_stall[i]` & ~`squash`.
  - A granted hold that captures new input in the same cycle reloads, giving back-to-back throughput of 1 per cycle per FU.
  - A granted hold with no new input clears.
  - A stalled hold keeps its contents. The FU keeps `fu_valid` and payload stable while stalled.
- **Lane outputs.** Lane outputs register the granted payloads. `out_valid[j]` is 1 for j < grant count and 0 otherwise. Payloads of invalid lanes are 0.
- **Pointer update.** If there is at least one grant, `rr_ptr` ← (index of last granted FU + 1) mod `NUM_FU`. With no grants, `rr_ptr` is unchanged.
- **Squash.** Next cycle, all `hold_valid` and `out_valid` are 0. `fu_valid` in the squash cycle is dropped. `rr_ptr` is retained. Squash has priority over capture and grant.
- **Reset.** All `hold_valid` are 0. All outputs are 0. `rr_ptr` is 0. `fu_stall` is 0.

## Timing
- Minimum latency: `fu_valid` sampled at edge t, held at t+1, granted in cycle t+1, `out_valid` from t+2 (2 cycles).
- `fu_stall` is valid in the same cycle, derived from registered state and `squash` only. There is no combinational path from `fu_valid` to `fu_stall`.
- Grant set and outputs depend only on registered holds. The `fu_*` to `out_*` path is fully registered.
- Full case: all `NUM_FU` holds occupied gives `WAYS` grants per cycle. Each of the remaining `NUM_FU`-`WAYS` FUs is stalled and is guaranteed a grant within ceil(`NUM_FU`/`WAYS`) cycles. Branch skipping can extend this by 1 cycle per extra branch.
- Empty case: no grants, all `out_valid`=0, `rr_ptr` holds.
- Reset asserted mid-operation overrides squash, capture, and grant. The cycle after, the state matches the reset state.

## Test plan
- **Reset:** assert `reset` for 2 cycles with all `fu_valid`=1 → every output 0, `fu_stall`=0, `rr_ptr`=0. The first captures happen on the edge after reset deasserts.
- **Single completion:** FU2 pr=7, rob=3, value=0xDEAD, valid for 1 cycle → two cycles later lane0 valid, pr 7, rob 3, fu_id 2. Lanes 1 and 2 invalid. No stalls.
- **Oversubscription:** FU0–4 valid every cycle, `rr_ptr`=0 → first grant cycle gives FU0,1,2 on lanes 0–2 with `fu_stall`=00011 (bit 0 = FU0), then `rr_ptr`=3. Next cycle grants FU3,4,0. No FU waits more than 2 grant cycles.
- **Branch limit:** FU1 and FU3 both held with `take_branch`=1, FU2 held with `take_branch`=0, `rr_ptr`=0 → grant FU1 and FU2. FU3 stalls and is granted in the next cycle.
- **Squash:** 4 holds occupied and squash asserted with FU0 valid → next cycle all `out_valid`=0, all holds empty, FU0 packet dropped, `rr_ptr` unchanged.
- **Back-to-back:** FU4 valid for 5 consecutive cycles with no other traffic → one output per cycle for 5 cycles and `fu_stall[4]`=0 throughout.
